alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Registered ALU-op decode and issue controller for the ID→EX boundary of the pipeline. It decodes opcode/funct3/funct7 into an ALUOp, including the RV32M multiply/divide extension and SRAI. It presents the op to EX through a valid/ready handshake. For multi-cycle operations it holds off further issue until the configured latency has elapsed, so ID stalls without a separate hazard path.

## Interface
- OP_W, 5: ALUOp width.
- ENABLE_M, 1: when 1, decode RV32M. When 0, M encodings are illegal.
- MUL_LAT, 2: EX cycles for MUL* ops. Must be ≥1.
- DIV_LAT, 32: EX cycles for DIV*/REM* ops. Must be ≥1.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  ID holds a decodable instruction.
- in_ready  out  1  controller accepts the instruction this cycle.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- flush  in  1  synchronous kill from branch/exception.
- out_valid  out  1  alu_op valid for EX.
- out_ready  in  1  EX accepts alu_op.
- alu_op  out  OP_W  decoded ALUOp.
- illegal  out  1  the held op had an undecodable encoding; qualified by out_valid.
- mc_busy  out  1  a multi-cycle op is executing.
- mc_done  out  1  single-cycle pulse in the final busy cycle.

## Operation
- Base decode is the RV32I mapping:
  - LUI, JALR, LOAD, STORE → ADD.
  - AUIPC, JAL → IDLE.
  - BRANCH uses funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Other funct3 values are illegal.
  - OP_IMM uses funct3 the same way as OP, except funct3=101 with funct7=0100000 → SRA (SRAI).
  - OP with funct7=0000000 or 0100000 uses the usual funct3 mapping. Any other combination, including SUB/SRA variants outside funct3 000/101, is illegal.
- M extension: opcode OP with funct7=0000001 uses funct3 000..111 → MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Unknown opcode or illegal combination: alu_op=IDLE, illegal=1. The op still issues so that EX/WB can raise the trap.
- Op class:
  - MUL* → MUL_LAT.
  - DIV*/REM* → DIV_LAT.
  - All others → 1.
  - A latency of 1 behaves as single-cycle.
- FSM states:
  - IDLE: nothing held. in_ready=1. On in_valid, latch the decode and go to HOLD.
  - HOLD: out_valid=1 and outputs are stable until out_ready.
    - Single-cycle op with out_ready: in_ready=1. On in_valid, latch the new op and stay in HOLD; otherwise go to IDLE.
    - Multi-cycle op with out_ready: load cnt=LAT-1 and go to BUSY. in_ready=0.
  - BUSY: mc_busy=1, in_ready=0, out_valid=0. cnt decrements each cycle. mc_done=1 when cnt==1. At the edge where cnt==1, go to IDLE.
- Counter width is $clog2(DIV_LAT+1). No wrap-around: cnt is never decremented below 1.
- flush has priority over every other event. Next state is IDLE, out_valid=0, cnt=0, mc_busy=0, and any accept in the same cycle is dropped. A flush during BUSY does not pulse mc_done.
- Reset, asynchronous and allowed mid-operation: state=IDLE, out_valid=0, alu_op=IDLE, illegal=0, mc_busy=0, mc_done=0, cnt=0. in_ready=1 once rst_n deasserts.

## Timing
- Decode latency is one cycle: an instruction accepted at edge N gives out_valid=1 after edge N.
- Throughput for single-cycle ops is one per cycle when out_ready=1 (pass-through in HOLD).
- Multi-cycle op with latency L, handshaken at edge T: mc_busy=1 for cycles T+1..T+L-1, mc_done=1 in cycle T+L-1, in_ready=1 again from cycle T+L.
- in_ready and mc_done are combinational from state, cnt, out_ready and the held class. alu_op, illegal and out_valid are registered.
- Backpressure: while out_ready=0 in HOLD, alu_op and illegal hold and in_ready=0.

## Structure
- The shared package alu_pkg holds:
  - Opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - OP_W.
  - ALUOp encodings: IDLE=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10, BEQ=11, BNE=12, BLT=13, BGE=14, BLTU=15, BGEU=16, MUL=17, MULH=18, MULHSU=19, MULHU=20, DIV=21, DIVU=22, REM=23, REMU=24.
  - The FSM state typedef.
- Sub-module alu_op_decode is combinational and produces alu_op, illegal and the latency class, taking ENABLE_M as a parameter. The FSM and counter live in alu_issue_ctrl.

## Test plan
- Reset: rst_n=0 mid-BUSY → all outputs at their reset values immediately. in_ready=1 after deassert.
- Back-to-back: three OP instructions ADD, SUB, SRA with out_ready=1 → alu_op 1, 2, 8 on consecutive cycles, no bubbles.
- Backpressure: XOR issued with out_ready=0 for 3 cycles → alu_op=6 held, in_ready=0, then accepted.
- Divide: DIV_LAT=4, DIV handshaken at T → mc_busy in T+1..T+3, mc_done at T+3, next instruction accepted at T+4.
- Flush mid-op: flush at T+2 during DIV → IDLE next cycle, no mc_done, in_ready=1.
- Illegal: ENABLE_M=0 with MUL encoding, plus OP funct7=0100000 funct3=001 → alu_op=0, illegal=1, out_valid=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ID->EX ALU issue path: opcodes, ALUOp
// encodings, latency classes and the issue FSM state type.
package alu_pkg;

   localparam int OP_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [OP_W-1:0] {
      ALU_IDLE = 5'd0, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
      ALU_BLTU, ALU_BGEU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
      ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_e;

   typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} lat_cls_e;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_BUSY} issue_state_e;

   // Shared funct3 table for OP and OP_IMM when no alternate funct7 applies.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle between ID (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] alu_op;
   logic            illegal;
   logic            mc_busy;
   logic            mc_done;

   modport master (
      output in_valid, opcode, funct3, funct7, flush, out_ready,
      input  in_ready, out_valid, alu_op, illegal, mc_busy, mc_done
   );

   modport slave (
      input  in_valid, opcode, funct3, funct7, flush, out_ready,
      output in_ready, out_valid, alu_op, illegal, mc_busy, mc_done
   );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I/RV32M decode to ALUOp, illegal flag and latency class.
module alu_op_decode
   import alu_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output alu_op_e    alu_op_o,
   output logic       illegal_o,
   output lat_cls_e   cls_o
);

   always_comb begin
      alu_op_o  = ALU_IDLE;
      illegal_o = 1'b0;
      cls_o     = CLS_SINGLE;
      case (opcode_i)
         OPC_LUI, OPC_JALR, OPC_LOAD, OPC_STORE: alu_op_o = ALU_ADD;
         OPC_AUIPC, OPC_JAL:                     alu_op_o = ALU_IDLE;
         OPC_BRANCH: begin
            case (funct3_i)
               3'b000:  alu_op_o = ALU_BEQ;
               3'b001:  alu_op_o = ALU_BNE;
               3'b100:  alu_op_o = ALU_BLT;
               3'b101:  alu_op_o = ALU_BGE;
               3'b110:  alu_op_o = ALU_BLTU;
               3'b111:  alu_op_o = ALU_BGEU;
               default: illegal_o = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            if (funct3_i == 3'b101 && funct7_i == F7_ALT) alu_op_o = ALU_SRA;
            else                                           alu_op_o = alu_from_funct3(funct3_i);
         end
         OPC_OP: begin
            case (funct7_i)
               F7_BASE: alu_op_o = alu_from_funct3(funct3_i);
               F7_ALT: begin
                  if (funct3_i == 3'b000)      alu_op_o  = ALU_SUB;
                  else if (funct3_i == 3'b101) alu_op_o  = ALU_SRA;
                  else                         illegal_o = 1'b1;
               end
               F7_MULDIV: begin
                  // MUL..REMU are contiguous, so funct3 is a direct offset.
                  if (ENABLE_M) begin
                     alu_op_o = alu_op_e'(ALU_MUL + {2'b00, funct3_i});
                     cls_o    = funct3_i[2] ? CLS_DIV : CLS_MUL;
                  end else begin
                     illegal_o = 1'b1;
                  end
               end
               default: illegal_o = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID->EX ALU issue controller: registered decode, valid/ready hand-off and
// a countdown that stalls ID for the duration of multi-cycle ops.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter bit          ENABLE_M = 1'b1,
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned DIV_LAT  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  bus
);

   // Sized so that either latency can be loaded without truncation.
   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int          CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   issue_state_e     state_q,   state_d;
   alu_op_e          alu_op_q,  alu_op_d;
   logic             illegal_q, illegal_d;
   lat_cls_e         cls_q,     cls_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   alu_op_e  dec_op;
   logic     dec_ill;
   lat_cls_e dec_cls;
   logic     held_multi;
   logic     in_ready_c;
   logic     mc_done_c;

   alu_op_decode #(.ENABLE_M(ENABLE_M)) u_decode (
      .opcode_i  (bus.opcode),
      .funct3_i  (bus.funct3),
      .funct7_i  (bus.funct7),
      .alu_op_o  (dec_op),
      .illegal_o (dec_ill),
      .cls_o     (dec_cls)
   );

   assign held_multi = (cls_q == CLS_MUL && MUL_LAT > 1) ||
                       (cls_q == CLS_DIV && DIV_LAT > 1);

   always_comb begin
      state_d    = state_q;
      alu_op_d   = alu_op_q;
      illegal_d  = illegal_q;
      cls_d      = cls_q;
      cnt_d      = cnt_q;
      in_ready_c = 1'b0;
      mc_done_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               alu_op_d  = dec_op;
               illegal_d = dec_ill;
               cls_d     = dec_cls;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               if (held_multi) begin
                  cnt_d   = (cls_q == CLS_DIV) ? DIV_LOAD : MUL_LOAD;
                  state_d = ST_BUSY;
               end else begin
                  in_ready_c = 1'b1;
                  if (bus.in_valid) begin
                     alu_op_d  = dec_op;
                     illegal_d = dec_ill;
                     cls_d     = dec_cls;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               mc_done_c = (cnt_q == CNT_ONE);
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Flush discards the held op and any same-cycle accept.
      if (bus.flush) begin
         state_d   = ST_IDLE;
         alu_op_d  = alu_op_q;
         illegal_d = illegal_q;
         cls_d     = cls_q;
         cnt_d     = '0;
         mc_done_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         alu_op_q  <= ALU_IDLE;
         illegal_q <= 1'b0;
         cls_q     <= CLS_SINGLE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         alu_op_q  <= alu_op_d;
         illegal_q <= illegal_d;
         cls_q     <= cls_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.alu_op    = alu_op_q;
   assign bus.illegal   = illegal_q;
   assign bus.mc_busy   = (state_q == ST_BUSY);
   assign bus.mc_done   = mc_done_c;

endmodule
